// File: rtl/cbus_arbiter.sv
// Arbitrates an instruction bus and a data bus onto a single memory port.
// One transaction is in flight at a time. Its request fields are latched when it is granted.
module cbus_arbiter #(
  parameter bit FIXED_DPRI = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  // ibus
  input  logic        i_valid,
  input  logic [63:0] i_addr,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  output logic [31:0] i_data,
  // dbus
  input  logic        d_valid,
  input  logic [63:0] d_addr,
  input  logic [2:0]  d_size,
  input  logic [7:0]  d_strobe,
  input  logic [63:0] d_wdata,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic [63:0] d_rdata,
  // memory
  output logic        m_valid,
  output logic        m_is_write,
  output logic [2:0]  m_size,
  output logic [63:0] m_addr,
  output logic [7:0]  m_strobe,
  output logic [63:0] m_wdata,
  input  logic        m_ready,
  input  logic        m_rvalid,
  input  logic [63:0] m_rdata,
  // debug
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ_I  = 3'd1,
    REQ_D  = 3'd2,
    WAIT_I = 3'd3,
    WAIT_D = 3'd4
  } state_t;

  state_t state, next_state;
  logic   last_grant_d;   // 1 = dbus was granted most recently
  logic   grant_d;
  logic   load;

  // Handshakes: a requester holds x_valid until x_data_ok. The memory accepts a
  // request on a cycle where m_valid & m_ready, and answers later with a one-cycle
  // m_rvalid. x_addr_ok and x_data_ok are combinational echoes of those two events.
  always_comb begin
    next_state = state;
    grant_d    = 1'b0;
    load       = 1'b0;
    m_valid    = 1'b0;
    i_addr_ok  = 1'b0;
    d_addr_ok  = 1'b0;
    i_data_ok  = 1'b0;
    d_data_ok  = 1'b0;
    case (state)
      IDLE: begin
        grant_d = d_valid & (~i_valid | FIXED_DPRI | ~last_grant_d);
        if (i_valid | d_valid) begin
          load       = 1'b1;
          next_state = grant_d ? REQ_D : REQ_I;
        end
      end
      REQ_I: begin
        m_valid   = 1'b1;
        i_addr_ok = m_ready;
        if (m_ready) next_state = WAIT_I;
      end
      REQ_D: begin
        m_valid   = 1'b1;
        d_addr_ok = m_ready;
        if (m_ready) next_state = WAIT_D;
      end
      WAIT_I: begin
        i_data_ok = m_rvalid;
        if (m_rvalid) next_state = IDLE;
      end
      WAIT_D: begin
        d_data_ok = m_rvalid;
        if (m_rvalid) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      last_grant_d <= 1'b1;
      m_is_write   <= 1'b0;
      m_size       <= 3'd0;
      m_addr       <= 64'd0;
      m_strobe     <= 8'd0;
      m_wdata      <= 64'd0;
    end else begin
      state <= next_state;
      if (i_data_ok) last_grant_d <= 1'b0;
      if (d_data_ok) last_grant_d <= 1'b1;
      if (load) begin
        if (grant_d) begin
          m_is_write <= (d_strobe != 8'd0);
          m_size     <= d_size;
          m_addr     <= d_addr;
          m_strobe   <= d_strobe;
          m_wdata    <= d_wdata;
        end else begin
          m_is_write <= 1'b0;
          m_size     <= 3'b010;
          m_addr     <= i_addr;
          m_strobe   <= 8'd0;
          m_wdata    <= 64'd0;
        end
      end
    end
  end

  // The fetch word is selected by bit 2 of the address that was latched, not the live one.
  assign i_data    = m_addr[2] ? m_rdata[63:32] : m_rdata[31:0];
  assign d_rdata   = m_rdata;
  assign dbg_state = state;

endmodule
